// File: rtl/mmc1_pkg.sv
// mmc1_pkg
// Shared types and constants for the extended MMC1 mapper: board variant
// and register-index enums, the fixed SDRAM base addresses for PRG RAM and
// CHR, the control register power-on value, and a helper that builds
// low-order address masks.

package mmc1_pkg;

   typedef enum logic [1:0] {
      BOARD_GENERIC = 2'd0,
      BOARD_SUROM   = 2'd1,
      BOARD_SOROM   = 2'd2,
      BOARD_SXROM   = 2'd3
   } board_t;

   // Register selected by CPU address bits [14:13] on the fifth serial write
   typedef enum logic [1:0] {
      REG_CONTROL    = 2'd0,
      REG_CHR_BANK_0 = 2'd1,
      REG_CHR_BANK_1 = 2'd2,
      REG_PRG_BANK   = 2'd3
   } reg_sel_t;

   localparam logic [21:0] PRG_RAM_BASE  = 22'h3C0000;
   localparam logic [21:0] CHR_BASE      = 22'h200000;
   localparam logic [4:0]  CONTROL_RESET = 5'b01100;

   // Mask with the low 'width' bits set, used to wrap smaller ROM images
   function automatic logic [21:0] addr_mask(input int width);
      return 22'((64'd1 << width) - 64'd1);
   endfunction

endpackage

// File: rtl/mmc1_serial_loader.sv
// mmc1_serial_loader
// Serial register loader of the MMC1: filters consecutive CPU write cycles,
// shifts in one data bit per accepted write and commits the fifth bit,
// together with the four stored bits, into one of the four mapper registers.
//
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   ce              one pulse per CPU cycle; nothing changes without it
//   enable          mapper selected; low returns everything to reset state
//   write           CPU write strobe
//   addr_hi         CPU address bits [15:13]
//   din_reset       CPU data bit 7 (loader reset request)
//   din_bit         CPU data bit 0 (serial data)
//   control, chr_bank_0, chr_bank_1, prg_bank   the mapper registers
//   load_count      serial bits accepted so far, 0..4

import mmc1_pkg::*;

module mmc1_serial_loader (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ce,
   input  logic       enable,
   input  logic       write,
   input  logic [2:0] addr_hi,
   input  logic       din_reset,
   input  logic       din_bit,
   output logic [4:0] control,
   output logic [4:0] chr_bank_0,
   output logic [4:0] chr_bank_1,
   output logic [4:0] prg_bank,
   output logic [2:0] load_count
);

   logic [3:0] shift;
   logic       wr_block;
   logic       accept;
   logic [4:0] commit_value;

   // A write only counts when the previous CPU cycle was not also a write;
   // this drops the second store of a read-modify-write instruction.
   assign accept       = write & addr_hi[2] & ~wr_block;
   assign commit_value = {din_bit, shift};

   // Loader state: a bit-7 write resets the shifter and forces PRG mode 3,
   // otherwise bits collect LSB first and the fifth write commits them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift      <= '0;
         load_count <= '0;
         control    <= CONTROL_RESET;
         chr_bank_0 <= '0;
         chr_bank_1 <= '0;
         prg_bank   <= '0;
         wr_block   <= 1'b0;
      end else if (!enable) begin
         shift      <= '0;
         load_count <= '0;
         control    <= CONTROL_RESET;
         chr_bank_0 <= '0;
         chr_bank_1 <= '0;
         prg_bank   <= '0;
         wr_block   <= 1'b0;
      end else if (ce) begin
         if (accept) begin
            wr_block <= 1'b1;
            if (din_reset) begin
               shift      <= '0;
               load_count <= '0;
               control    <= control | CONTROL_RESET;
            end else if (load_count < 3'd4) begin
               shift[load_count[1:0]] <= din_bit;
               load_count             <= load_count + 3'd1;
            end else begin
               case (reg_sel_t'(addr_hi[1:0]))
                  REG_CONTROL:    control    <= commit_value;
                  REG_CHR_BANK_0: chr_bank_0 <= commit_value;
                  REG_CHR_BANK_1: chr_bank_1 <= commit_value;
                  REG_PRG_BANK:   prg_bank   <= commit_value;
                  default:        control    <= commit_value;
               endcase
               shift      <= '0;
               load_count <= '0;
            end
         end else if (!write) begin
            wr_block <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mmc1_ext_mapper.sv
// mmc1_ext_mapper
// Extended MMC1 mapper (SxROM, SUROM, SOROM, SXROM). Translates CPU and PPU
// addresses into linear SDRAM addresses and drives nametable A10 / VRAM CE.
// All register state lives in mmc1_serial_loader; this level is pure decode.
//
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   ce             M2 clock enable, one pulse per CPU cycle
//   enable         mapper selected; low acts as synchronous reset
//   prg_ain        CPU address;  prg_write / prg_din  CPU write strobe / data
//   chr_ain        PPU address;  chr_ram  cart uses CHR RAM
//   prg_aout       linear PRG address;  prg_allow / prg_open_bus  access control
//   chr_aout       linear CHR address;  chr_allow  CHR write permitted
//   vram_a10       nametable A10;  vram_ce  route to internal VRAM
//   load_count     serial bits accepted so far

import mmc1_pkg::*;

module mmc1_ext_mapper #(
   parameter int PRG_ROM_AW = 19,
   parameter int CHR_AW     = 17,
   parameter int MMC1A      = 0,
   parameter int BOARD      = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ce,
   input  logic        enable,
   input  logic [15:0] prg_ain,
   input  logic        prg_write,
   input  logic [7:0]  prg_din,
   input  logic [13:0] chr_ain,
   input  logic        chr_ram,
   output logic [21:0] prg_aout,
   output logic        prg_allow,
   output logic        prg_open_bus,
   output logic [21:0] chr_aout,
   output logic        chr_allow,
   output logic        vram_a10,
   output logic        vram_ce,
   output logic [2:0]  load_count
);

   localparam board_t      BOARD_SEL  = board_t'(BOARD[1:0]);
   // The large-board variants only carry 8 KB of CHR; their CHR bank bits
   // are repurposed for PRG ROM / PRG RAM banking.
   localparam int          EFF_CHR_AW = (BOARD_SEL == BOARD_GENERIC) ? CHR_AW : 13;
   localparam logic [21:0] PRG_MASK   = addr_mask(PRG_ROM_AW);
   localparam logic [21:0] CHR_MASK   = addr_mask(EFF_CHR_AW);
   localparam logic        RAM_DISABLE_USED = (MMC1A == 0);

   logic [4:0]  control;
   logic [4:0]  chr_bank_0;
   logic [4:0]  chr_bank_1;
   logic [4:0]  prg_bank;
   logic [3:0]  prg_sel;
   logic        prg_outer;
   logic [1:0]  ram_bank;
   logic [21:0] rom_addr;
   logic [21:0] ram_addr;
   logic [4:0]  chr_sel;
   logic        din_unused;

   assign din_unused = ^prg_din[6:1];

   mmc1_serial_loader loader (
      .clk        (clk),
      .reset_n    (reset_n),
      .ce         (ce),
      .enable     (enable),
      .write      (prg_write),
      .addr_hi    (prg_ain[15:13]),
      .din_reset  (prg_din[7]),
      .din_bit    (prg_din[0]),
      .control    (control),
      .chr_bank_0 (chr_bank_0),
      .chr_bank_1 (chr_bank_1),
      .prg_bank   (prg_bank),
      .load_count (load_count)
   );

   // 16 KB PRG bank selection: 32 KB mode ignores bank bit 0; modes 2 and 3
   // fix the first or last bank and switch the other half.
   always_comb begin
      prg_sel = '0;
      case (control[3:2])
         2'b10:   prg_sel = prg_ain[14] ? prg_bank[3:0] : 4'h0;
         2'b11:   prg_sel = prg_ain[14] ? 4'hF : prg_bank[3:0];
         default: prg_sel = {prg_bank[3:1], prg_ain[14]};
      endcase
   end

   // SUROM/SXROM use CHR bank 0 bit 4 as the 256 KB outer PRG ROM bank;
   // SOROM/SXROM use CHR bank 0 bits [3:2] to bank the 8 KB PRG RAM.
   always_comb begin
      prg_outer = 1'b0;
      ram_bank  = 2'b00;
      case (BOARD_SEL)
         BOARD_SUROM: prg_outer = chr_bank_0[4];
         BOARD_SOROM: ram_bank  = {1'b0, chr_bank_0[3]};
         BOARD_SXROM: begin
            prg_outer = chr_bank_0[4];
            ram_bank  = chr_bank_0[3:2];
         end
         default: ;
      endcase
   end

   assign rom_addr = {3'b000, prg_outer, prg_sel, prg_ain[13:0]} & PRG_MASK;
   assign ram_addr = PRG_RAM_BASE | {7'b0, ram_bank, prg_ain[12:0]};

   // CPU region decode: ROM at $8000+, RAM at $6000-$7FFF, nothing below.
   // The RAM disable bit of prg_bank only exists on MMC1B and later.
   always_comb begin
      prg_aout     = '0;
      prg_allow    = 1'b0;
      prg_open_bus = 1'b0;
      if (prg_ain[15]) begin
         prg_aout  = rom_addr;
         prg_allow = ~prg_write;
      end else if (prg_ain[14:13] == 2'b11) begin
         prg_aout = ram_addr;
         if (prg_bank[4] && RAM_DISABLE_USED) begin
            prg_open_bus = 1'b1;
         end else begin
            prg_allow = 1'b1;
         end
      end
   end

   // CHR: 8 KB mode ignores bank 0 bit 0; 4 KB mode picks a bank per half
   assign chr_sel   = control[4] ? (chr_ain[12] ? chr_bank_1 : chr_bank_0)
                                 : {chr_bank_0[4:1], chr_ain[12]};
   assign chr_aout  = CHR_BASE | ({5'b0, chr_sel, chr_ain[11:0]} & CHR_MASK);
   assign chr_allow = chr_ram;
   assign vram_ce   = chr_ain[13];

   // Mirroring: one-screen low/high, vertical, horizontal
   always_comb begin
      vram_a10 = 1'b0;
      case (control[1:0])
         2'b00:   vram_a10 = 1'b0;
         2'b01:   vram_a10 = 1'b1;
         2'b10:   vram_a10 = chr_ain[10];
         default: vram_a10 = chr_ain[11];
      endcase
   end

endmodule

// File: tb/tb_mmc1_ext_mapper.sv
// tb_mmc1_ext_mapper
// Directed bench for mmc1_ext_mapper. Four mapper instances share one CPU/PPU
// stimulus stream so board and MMC1A variants can be compared side by side:
//   [0] generic, 256 KB PRG   [1] SUROM   [2] SXROM MMC1B   [3] SXROM MMC1A

module tb_mmc1_ext_mapper;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ce;
   logic        enable;
   logic [15:0] prg_ain;
   logic        prg_write;
   logic [7:0]  prg_din;
   logic [13:0] chr_ain;
   logic        chr_ram;

   logic [21:0] prg_aout     [4];
   logic        prg_allow    [4];
   logic        prg_open_bus [4];
   logic [21:0] chr_aout     [4];
   logic        chr_allow    [4];
   logic        vram_a10     [4];
   logic        vram_ce      [4];
   logic [2:0]  load_count   [4];

   int check_count = 0;
   int error_count = 0;

   always #5 clk = ~clk;

   mmc1_ext_mapper #(.PRG_ROM_AW(18), .CHR_AW(17), .MMC1A(0), .BOARD(0)) dut_generic (
      .clk(clk), .reset_n(reset_n), .ce(ce), .enable(enable),
      .prg_ain(prg_ain), .prg_write(prg_write), .prg_din(prg_din),
      .chr_ain(chr_ain), .chr_ram(chr_ram),
      .prg_aout(prg_aout[0]), .prg_allow(prg_allow[0]), .prg_open_bus(prg_open_bus[0]),
      .chr_aout(chr_aout[0]), .chr_allow(chr_allow[0]), .vram_a10(vram_a10[0]),
      .vram_ce(vram_ce[0]), .load_count(load_count[0]));

   mmc1_ext_mapper #(.PRG_ROM_AW(19), .CHR_AW(17), .MMC1A(0), .BOARD(1)) dut_surom (
      .clk(clk), .reset_n(reset_n), .ce(ce), .enable(enable),
      .prg_ain(prg_ain), .prg_write(prg_write), .prg_din(prg_din),
      .chr_ain(chr_ain), .chr_ram(chr_ram),
      .prg_aout(prg_aout[1]), .prg_allow(prg_allow[1]), .prg_open_bus(prg_open_bus[1]),
      .chr_aout(chr_aout[1]), .chr_allow(chr_allow[1]), .vram_a10(vram_a10[1]),
      .vram_ce(vram_ce[1]), .load_count(load_count[1]));

   mmc1_ext_mapper #(.PRG_ROM_AW(19), .CHR_AW(17), .MMC1A(0), .BOARD(3)) dut_sxrom_b (
      .clk(clk), .reset_n(reset_n), .ce(ce), .enable(enable),
      .prg_ain(prg_ain), .prg_write(prg_write), .prg_din(prg_din),
      .chr_ain(chr_ain), .chr_ram(chr_ram),
      .prg_aout(prg_aout[2]), .prg_allow(prg_allow[2]), .prg_open_bus(prg_open_bus[2]),
      .chr_aout(chr_aout[2]), .chr_allow(chr_allow[2]), .vram_a10(vram_a10[2]),
      .vram_ce(vram_ce[2]), .load_count(load_count[2]));

   mmc1_ext_mapper #(.PRG_ROM_AW(19), .CHR_AW(17), .MMC1A(1), .BOARD(3)) dut_sxrom_a (
      .clk(clk), .reset_n(reset_n), .ce(ce), .enable(enable),
      .prg_ain(prg_ain), .prg_write(prg_write), .prg_din(prg_din),
      .chr_ain(chr_ain), .chr_ram(chr_ram),
      .prg_aout(prg_aout[3]), .prg_allow(prg_allow[3]), .prg_open_bus(prg_open_bus[3]),
      .chr_aout(chr_aout[3]), .chr_allow(chr_allow[3]), .vram_a10(vram_a10[3]),
      .vram_ce(vram_ce[3]), .load_count(load_count[3]));

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One CPU cycle with ce asserted; outputs are settled 1 ns after the edge
   task automatic applyStimulus(input logic wr, input logic [15:0] addr,
                                input logic [7:0] data);
      @(negedge clk);
      prg_write = wr;
      prg_ain   = addr;
      prg_din   = data;
      ce        = 1'b1;
      @(posedge clk);
      #1;
      ce        = 1'b0;
      prg_write = 1'b0;
   endtask

   // A store followed by a read cycle, as a normal STA instruction would do
   task automatic serialWrite(input logic [15:0] addr, input logic b);
      applyStimulus(1'b1, addr, {7'b0, b});
      applyStimulus(1'b0, addr, 8'h00);
   endtask

   task automatic loadReg(input logic [15:0] addr, input logic [4:0] value);
      for (int i = 0; i < 5; i++) serialWrite(addr, value[i]);
   endtask

   task automatic peek(input logic [15:0] addr, input logic [13:0] chr);
      prg_ain   = addr;
      chr_ain   = chr;
      prg_write = 1'b0;
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      enable    = 1'b1;
      ce        = 1'b0;
      prg_write = 1'b0;
      prg_ain   = '0;
      prg_din   = '0;
      chr_ain   = '0;
      chr_ram   = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // Reset state: control 0x0C -> PRG mode 3, one-screen low mirroring
      peek(16'h8000, 14'h0400);
      checkOutput("reset_load_count", 32'(load_count[0]), 32'd0);
      checkOutput("reset_a10", 32'(vram_a10[0]), 32'd0);
      checkOutput("reset_prg_8000", 32'(prg_aout[0]), 32'h00000);
      checkOutput("chr_allow_on", 32'(chr_allow[0]), 32'd1);
      checkOutput("vram_ce_low", 32'(vram_ce[0]), 32'd0);
      peek(16'hC000, 14'h0000);
      checkOutput("reset_prg_c000", 32'(prg_aout[0]), 32'h3C000);

      // control = 0x0E loaded LSB first
      serialWrite(16'h8000, 1'b0);
      serialWrite(16'h8000, 1'b1);
      serialWrite(16'h8000, 1'b1);
      serialWrite(16'h8000, 1'b1);
      checkOutput("count_after_4", 32'(load_count[0]), 32'd4);
      serialWrite(16'h8000, 1'b0);
      checkOutput("count_after_commit", 32'(load_count[0]), 32'd0);
      peek(16'h8000, 14'h0400);
      checkOutput("vert_a10_hi", 32'(vram_a10[0]), 32'd1);
      peek(16'h8000, 14'h0800);
      checkOutput("vert_a10_lo", 32'(vram_a10[0]), 32'd0);

      // PRG mode 3 with prg_bank = 5
      loadReg(16'hE000, 5'h05);
      peek(16'h8000, 14'h0000);
      checkOutput("m3_prg_8000", 32'(prg_aout[0]), 32'h14000);
      checkOutput("m3_prg_8000_su", 32'(prg_aout[1]), 32'h14000);
      peek(16'hC000, 14'h0000);
      checkOutput("m3_prg_c000", 32'(prg_aout[0]), 32'h3C000);

      // chr_bank_0 = 0x10 selects the upper 256 KB on SUROM only
      loadReg(16'hA000, 5'h10);
      peek(16'hC000, 14'h0000);
      checkOutput("surom_outer_c000", 32'(prg_aout[1]), 32'h7C000);
      checkOutput("generic_no_outer", 32'(prg_aout[0]), 32'h3C000);
      peek(16'h8000, 14'h1123);
      checkOutput("surom_outer_8000", 32'(prg_aout[1]), 32'h54000);
      checkOutput("chr8k_generic", 32'(chr_aout[0]), 32'h211123);
      checkOutput("chr8k_surom_wrap", 32'(chr_aout[1]), 32'h201123);

      loadReg(16'hA000, 5'h0C);
      peek(16'hC000, 14'h0000);
      checkOutput("surom_inner_c000", 32'(prg_aout[1]), 32'h3C000);

      // chr_bank_1 = 7, control = 0x12: 32 KB PRG, 4 KB CHR, vertical
      loadReg(16'hC000, 5'h07);
      loadReg(16'h8000, 5'h12);
      peek(16'h8000, 14'h1ABC);
      checkOutput("m0_prg_8000", 32'(prg_aout[0]), 32'h10000);
      checkOutput("chr4k_hi", 32'(chr_aout[0]), 32'h207ABC);
      peek(16'hC000, 14'h0ABC);
      checkOutput("m0_prg_c000", 32'(prg_aout[0]), 32'h14000);
      checkOutput("chr4k_lo", 32'(chr_aout[0]), 32'h20CABC);
      checkOutput("chr4k_lo_sxrom", 32'(chr_aout[2]), 32'h200ABC);

      // Back-to-back write cycles: only the first one registers
      applyStimulus(1'b1, 16'hE000, 8'h01);
      applyStimulus(1'b1, 16'hE000, 8'h00);
      checkOutput("rmw_filtered", 32'(load_count[0]), 32'd1);
      applyStimulus(1'b0, 16'hE000, 8'h00);
      applyStimulus(1'b1, 16'hE000, 8'h00);
      checkOutput("after_idle_write", 32'(load_count[0]), 32'd2);
      applyStimulus(1'b0, 16'hE000, 8'h00);
      applyStimulus(1'b1, 16'hE000, 8'h01);
      applyStimulus(1'b0, 16'hE000, 8'h00);
      checkOutput("three_bits", 32'(load_count[0]), 32'd3);

      // Bit-7 write: clears the shifter and sets PRG mode 3 only
      applyStimulus(1'b1, 16'hE000, 8'h80);
      checkOutput("bit7_count", 32'(load_count[0]), 32'd0);
      applyStimulus(1'b0, 16'hE000, 8'h00);
      peek(16'hC000, 14'h1ABC);
      checkOutput("bit7_mode3_c000", 32'(prg_aout[0]), 32'h3C000);
      checkOutput("bit7_chr4k_kept", 32'(chr_aout[0]), 32'h207ABC);
      peek(16'h8000, 14'h0000);
      checkOutput("bit7_prg_kept", 32'(prg_aout[0]), 32'h14000);

      // PRG RAM disable bit and SXROM RAM banking (chr_bank_0 = 0x0C)
      loadReg(16'hE000, 5'h10);
      peek(16'h6000, 14'h0000);
      checkOutput("mmc1b_ram_allow", 32'(prg_allow[2]), 32'd0);
      checkOutput("mmc1b_ram_open", 32'(prg_open_bus[2]), 32'd1);
      checkOutput("mmc1a_ram_allow", 32'(prg_allow[3]), 32'd1);
      checkOutput("mmc1a_ram_open", 32'(prg_open_bus[3]), 32'd0);
      checkOutput("sxrom_ram_addr", 32'(prg_aout[3]), 32'h3C6000);
      checkOutput("generic_ram_addr", 32'(prg_aout[0]), 32'h3C0000);
      checkOutput("generic_ram_disabled", 32'(prg_allow[0]), 32'd0);
      peek(16'h7FFF, 14'h0000);
      checkOutput("sxrom_ram_top", 32'(prg_aout[3]), 32'h3C7FFF);
      peek(16'h8000, 14'h0000);
      checkOutput("rom_bank0_8000", 32'(prg_aout[0]), 32'h00000);
      checkOutput("rom_read_allow", 32'(prg_allow[0]), 32'd1);
      checkOutput("rom_no_open_bus", 32'(prg_open_bus[0]), 32'd0);
      peek(16'h4020, 14'h0000);
      checkOutput("low_allow", 32'(prg_allow[3]), 32'd0);
      checkOutput("low_open_bus", 32'(prg_open_bus[3]), 32'd0);

      // Write strobe without ce: ROM write refused and no state change
      prg_ain   = 16'h8000;
      prg_din   = 8'h01;
      prg_write = 1'b1;
      #1;
      checkOutput("rom_write_refused", 32'(prg_allow[0]), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("no_ce_no_load", 32'(load_count[0]), 32'd0);
      prg_write = 1'b0;

      // Remaining mirroring modes
      loadReg(16'h8000, 5'h0D);
      peek(16'h8000, 14'h0000);
      checkOutput("onescreen_hi", 32'(vram_a10[0]), 32'd1);
      loadReg(16'h8000, 5'h0F);
      peek(16'h8000, 14'h0800);
      checkOutput("horiz_a10_hi", 32'(vram_a10[0]), 32'd1);
      peek(16'h8000, 14'h0400);
      checkOutput("horiz_a10_lo", 32'(vram_a10[0]), 32'd0);
      chr_ram = 1'b0;
      peek(16'h8000, 14'h2000);
      checkOutput("chr_allow_off", 32'(chr_allow[0]), 32'd0);
      checkOutput("vram_ce_high", 32'(vram_ce[0]), 32'd1);

      // enable low acts as a synchronous reset, discarding partial bits
      serialWrite(16'h8000, 1'b1);
      serialWrite(16'h8000, 1'b1);
      checkOutput("partial_before_en", 32'(load_count[0]), 32'd2);
      @(negedge clk);
      enable = 1'b0;
      @(posedge clk);
      #1;
      enable = 1'b1;
      checkOutput("enable_reset_count", 32'(load_count[0]), 32'd0);
      peek(16'h6000, 14'h0400);
      checkOutput("enable_reset_a10", 32'(vram_a10[0]), 32'd0);
      checkOutput("enable_reset_ram_on", 32'(prg_allow[2]), 32'd1);

      // Asynchronous reset mid-load takes effect without a clock edge
      serialWrite(16'h8000, 1'b1);
      serialWrite(16'h8000, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset_count", 32'(load_count[0]), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      loadReg(16'hE000, 5'h03);
      peek(16'h8000, 14'h0000);
      checkOutput("clean_load_after_reset", 32'(prg_aout[0]), 32'h0C000);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
